rsc_term_encoder: RTL and testbench
===================================

Name: rsc_term_encoder

Overview:
Parametrised recursive systematic convolutional (RSC) constituent encoder with built-in trellis termination and valid/ready handshakes on both sides. It replaces the fixed-polynomial, two-clock (clk/clk_slow) encoder datapath with a single-clock core. It accepts a programmable block of K information bits and then appends MEM tail steps. Two instances, one fed through the interleaver, form the turbo encoder.

Parameters:
MEM, 3, encoder memory (number of state bits); constraint length is MEM+1.
G_FB, 4'b1011, feedback polynomial, MEM+1 bits; bit (MEM-i) is the coefficient of D^i. Default is 1+D^2+D^3.
G_FF, 4'b1101, feedforward polynomial, same encoding. Default is 1+D+D^3.
K_MAX, 6144, maximum block length in bits.
LEN_W, $clog2(K_MAX+1), width of blk_len and the internal counter.

Ports:
clk  in  1  single clock; all state changes on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; latches blk_len and begins a block. Accepted only in IDLE.
blk_len  in  LEN_W  number of info bits K; legal range 1..K_MAX.
in_bit  in  1  information bit.
in_valid  in  1  in_bit is valid.
in_ready  out  1  core accepts in_bit this cycle.
out_sys  out  1  systematic bit (info bit or tail bit).
out_par  out  1  parity bit.
out_valid  out  1  out_sys/out_par are valid.
out_ready  in  1  downstream accepts output.
out_tail  out  1  current output is a tail step.
out_last  out  1  current output is the final tail step of the block.
busy  out  1  high from accepted start until the last tail output is accepted.
len_err  out  1  sticky flag; set when start arrives with blk_len==0 or blk_len>K_MAX; cleared by the next accepted start.

Behaviour:
- Reset (async assert, synchronous deassert by the integrator): state=IDLE, shift register s[1..MEM]=0, counter=0, and every output = 0.
- Encoder arithmetic:
  - a = u XOR (XOR over i=1..MEM of G_FB[MEM-i] & s[i]).
  - p = (G_FF[MEM] & a) XOR (XOR over i=1..MEM of G_FF[MEM-i] & s[i]).
  - Next state: s[1]<=a, s[i]<=s[i-1].
- Tail step: u = XOR over i=1..MEM of G_FB[MEM-i] & s[i]. This forces a=0, so after MEM tail steps s is all zero. Emit out_sys=u, out_par=p.
- Output register: a single slot. "slot free" = !out_valid || out_ready.
- FSM:
  - IDLE: on start with a legal blk_len, latch K, counter<=0, busy<=1, go to DATA. On start with an illegal blk_len, set len_err and stay in IDLE.
  - DATA: in_ready = slot free. On in_valid && in_ready, encode u=in_bit and load the slot (out_valid<=1, out_tail=0). Counter increments; when counter reaches K-1 on an accepted bit, go to TAIL with counter<=0.
  - TAIL: whenever the slot is free, perform one tail step and load the slot with out_tail=1. out_last=1 on step MEM. After that step is loaded, go to IDLE. busy falls when the last output is accepted.
- Latency: an accepted input appears on the outputs on the next cycle.
- Outputs hold stable while out_valid && !out_ready.
- in_ready is 0 in IDLE and TAIL.
- start outside IDLE is ignored and does not set len_err.
- A new start is legal in IDLE while the final output is still pending. The register is cleared at block start.
- Throughput: 1 bit/cycle when out_ready=1. K+MEM output cycles per block.
- Reset mid-block aborts immediately: no residual state and no partial tail.

Decomposition:
- Package turbo_pkg holds:
  - default polynomial constants G_FB_LTE=4'b1011 and G_FF_LTE=4'b1101;
  - K_MAX_LTE=6144;
  - an FSM state enum {IDLE, DATA, TAIL};
  - a function rsc_step(u, s, g_fb, g_ff) returning {a, p}.
- One natural sub-module: rsc_trellis_reg. It is the MEM-bit shift register plus next-state/parity logic and is shared by both turbo constituents.

Test Plan:
- Basic block: blk_len=4, bits 1,0,0,0, out_ready=1.
  - Data outputs: sys 1,0,0,0 and par 1,1,1,1.
  - Tail outputs: sys 1,0,1 and par 1,1,1, with out_tail=1 on the 3 tail cycles and out_last only on the 3rd.
  - Internal state = 000 at the end; busy low after 7 outputs.
- Backpressure: same stimulus with out_ready toggling 1,0,0,1,...
  - Identical sequence of 7 output pairs, with no drop or duplication.
  - Outputs stable while stalled; in_ready=0 whenever the slot is full and not being drained.
- Length errors:
  - start with blk_len=0 -> len_err=1, busy=0, stays IDLE.
  - start with blk_len=K_MAX+1 -> same response.
  - Next start with blk_len=4 -> len_err=0 and the block proceeds normally.
- Back-to-back blocks: start asserted the cycle after out_last is accepted, blk_len=6144, random bits.
  - Outputs match the golden model file bit-exactly: 6147 pairs per block, over 3 blocks.
- Ignored start and mid-block reset: start pulse in DATA is ignored (counter unaffected); then reset_n=0 in the middle of TAIL.
  - All outputs 0 on the same cycle; the block after reset matches the golden output from zero state.
- Parametrisation: MEM=2, G_FB=3'b111, G_FF=3'b101, blk_len=3, bits 1,1,0.
  - Compare against the reference model.
  - The 2 tail steps return the state to 00.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types, default LTE polynomials and the RSC step function used by both
// turbo constituent encoders.
package turbo_pkg;

    localparam logic [3:0]  G_FB_LTE  = 4'b1011;  // 1 + D^2 + D^3
    localparam logic [3:0]  G_FF_LTE  = 4'b1101;  // 1 + D + D^3
    localparam int unsigned K_MAX_LTE = 6144;
    // Upper bound on encoder memory accepted by rsc_step.
    localparam int unsigned MEM_MAX   = 8;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} rsc_state_e;

    // s[i-1] holds register stage i; bit (mem-i) of a polynomial weights stage i.
    function automatic logic [1:0] rsc_step(
        input logic               u,
        input logic [MEM_MAX-1:0] s,
        input logic [MEM_MAX:0]   g_fb,
        input logic [MEM_MAX:0]   g_ff,
        input int unsigned        mem
    );
        logic fb;
        logic ff;
        logic a;
        fb = 1'b0;
        ff = 1'b0;
        for (int unsigned i = 1; i <= MEM_MAX; i++) begin
            if (i <= mem) begin
                fb = fb ^ (g_fb[mem-i] & s[i-1]);
                ff = ff ^ (g_ff[mem-i] & s[i-1]);
            end
        end
        a = u ^ fb;
        return {a, (g_ff[mem] & a) ^ ff};
    endfunction

endpackage

// File: rtl/rsc_term_encoder_if.sv
// Input and output streams of the RSC encoder, each with a valid/ready handshake.
interface rsc_term_encoder_if;

    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out_sys;
    logic out_par;
    logic out_valid;
    logic out_ready;
    logic out_tail;
    logic out_last;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_sys, out_par, out_valid, out_tail, out_last
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_sys, out_par, out_valid, out_tail, out_last
    );

endinterface

// File: rtl/rsc_trellis_reg.sv
// MEM-bit RSC shift register with systematic/parity generation for data and
// termination steps.
module rsc_trellis_reg
    import turbo_pkg::*;
#(
    parameter int unsigned  MEM  = 3,
    parameter logic [MEM:0] G_FB = G_FB_LTE,
    parameter logic [MEM:0] G_FF = G_FF_LTE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic tail,
    input  logic u_in,
    output logic sys,
    output logic par
);

    localparam logic [MEM_MAX:0] GfbExt = (MEM_MAX+1)'(G_FB);
    localparam logic [MEM_MAX:0] GffExt = (MEM_MAX+1)'(G_FF);

    logic [MEM-1:0]     state_q;
    logic [MEM_MAX-1:0] s_ext;
    logic [1:0]         data_res;
    logic [1:0]         fb_res;
    logic               a;

    assign s_ext = MEM_MAX'(state_q);

    always_comb begin
        data_res = rsc_step(u_in, s_ext, GfbExt, GffExt, MEM);
        fb_res   = rsc_step(1'b0, s_ext, GfbExt, GffExt, MEM);
    end

    // With u=0 the step's a equals the feedback sum; a tail step feeds that back as u,
    // so the true a is 0 and the a-term must be stripped from the parity.
    assign sys = tail ? fb_res[1] : u_in;
    assign par = tail ? (fb_res[0] ^ (G_FF[MEM] & fb_res[1])) : data_res[0];
    assign a   = tail ? 1'b0 : data_res[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
        end else if (clr) begin
            state_q <= '0;
        end else if (en) begin
            state_q <= {state_q[MEM-2:0], a};
        end
    end

endmodule

// File: rtl/rsc_term_encoder.sv
// Single-clock RSC constituent encoder: K info bits followed by MEM termination
// steps, streamed through a one-entry output slot.
module rsc_term_encoder
    import turbo_pkg::*;
#(
    parameter int unsigned  MEM   = 3,
    parameter logic [MEM:0] G_FB  = G_FB_LTE,
    parameter logic [MEM:0] G_FF  = G_FF_LTE,
    parameter int unsigned  K_MAX = K_MAX_LTE,
    parameter int unsigned  LEN_W = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] blk_len,
    rsc_term_encoder_if.slave bus,
    output logic             busy,
    output logic             len_err
);

    rsc_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic             valid_q, valid_d;
    logic             sys_q, sys_d;
    logic             par_q, par_d;
    logic             tail_q, tail_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             len_err_q, len_err_d;
    logic             slot_free;
    logic             step_en;
    logic             step_tail;
    logic             trel_clr;
    logic             trel_sys;
    logic             trel_par;
    logic             tail_done;

    assign slot_free    = !valid_q || bus.out_ready;
    assign step_tail    = (state_q == TAIL);
    assign tail_done    = (cnt_q == LEN_W'(MEM - 1));
    assign bus.in_ready = (state_q == DATA) && slot_free;

    rsc_trellis_reg #(
        .MEM  (MEM),
        .G_FB (G_FB),
        .G_FF (G_FF)
    ) u_trellis (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (trel_clr),
        .en      (step_en),
        .tail    (step_tail),
        .u_in    (bus.in_bit),
        .sys     (trel_sys),
        .par     (trel_par)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        valid_d   = valid_q;
        sys_d     = sys_q;
        par_d     = par_q;
        tail_d    = tail_q;
        last_d    = last_q;
        busy_d    = busy_q;
        len_err_d = len_err_q;
        step_en   = 1'b0;
        trel_clr  = 1'b0;

        // Drain first so a same-cycle reload or new start wins.
        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
            tail_d  = 1'b0;
            last_d  = 1'b0;
            if (last_q) begin
                busy_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (blk_len == '0 || blk_len > LEN_W'(K_MAX)) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_err_d = 1'b0;
                        k_d       = blk_len;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        trel_clr  = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.in_valid && slot_free) begin
                    step_en = 1'b1;
                    valid_d = 1'b1;
                    sys_d   = trel_sys;
                    par_d   = trel_par;
                    tail_d  = 1'b0;
                    last_d  = 1'b0;
                    if (cnt_q == k_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = TAIL;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    step_en = 1'b1;
                    valid_d = 1'b1;
                    sys_d   = trel_sys;
                    par_d   = trel_par;
                    tail_d  = 1'b1;
                    last_d  = tail_done;
                    if (tail_done) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            valid_q   <= 1'b0;
            sys_q     <= 1'b0;
            par_q     <= 1'b0;
            tail_q    <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            valid_q   <= valid_d;
            sys_q     <= sys_d;
            par_q     <= par_d;
            tail_q    <= tail_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_sys   = sys_q;
    assign bus.out_par   = par_q;
    assign bus.out_tail  = tail_q;
    assign bus.out_last  = last_q;
    assign busy          = busy_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_rsc_term_encoder.sv
// Directed bench for rsc_term_encoder: default LTE instance plus a MEM=2 instance.
module tb_rsc_term_encoder;

    localparam int LEN_W = 13;

    logic             clk;
    logic             reset_n;
    logic             start_a, start_b;
    logic [LEN_W-1:0] blk_len_a, blk_len_b;
    logic             busy_a, busy_b;
    logic             len_err_a, len_err_b;

    int n_assert = 0;
    int n_fail   = 0;

    rsc_term_encoder_if bus_a ();
    rsc_term_encoder_if bus_b ();

    rsc_term_encoder dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_a),
        .blk_len (blk_len_a),
        .bus     (bus_a),
        .busy    (busy_a),
        .len_err (len_err_a)
    );

    rsc_term_encoder #(
        .MEM  (2),
        .G_FB (3'b111),
        .G_FF (3'b101)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_b),
        .blk_len (blk_len_b),
        .bus     (bus_b),
        .busy    (busy_b),
        .len_err (len_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Independent model written directly for 1+D^2+D^3 / 1+D+D^3; entries {tail,last,sys,par}.
    task automatic ref_encode(input logic bits[$], output logic [3:0] expq[$]);
        logic s1, s2, s3, u, a, p;
        s1 = 0; s2 = 0; s3 = 0;
        expq = {};
        foreach (bits[i]) begin
            u = bits[i];
            a = u ^ s2 ^ s3;
            p = a ^ s1 ^ s3;
            expq.push_back({2'b00, u, p});
            s3 = s2; s2 = s1; s1 = a;
        end
        for (int t = 0; t < 3; t++) begin
            u = s2 ^ s3;
            p = s1 ^ s3;
            expq.push_back({1'b1, (t == 2), u, p});
            s3 = s2; s2 = s1; s1 = 1'b0;
        end
    endtask

    task automatic compare_block(input string tag, input logic [3:0] got[$],
                                 input logic [3:0] expq[$]);
        check({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), 32'(got[i]), 32'(expq[i]));
        end
    endtask

    // Runs one block on dut_a; optional out_ready pattern 1,0,0,1 repeating.
    task automatic run_a(input logic bits[$], input bit bp, output logic [3:0] got[$]);
        int         bi, cyc, budget;
        logic [3:0] prev, cur;
        bit         stalled, done;
        got = {};
        bi = 0; cyc = 0; stalled = 0; done = 0; prev = '0;
        budget = 4 * (bits.size() + 3) + 20;
        start_a   = 1'b1;
        blk_len_a = LEN_W'(bits.size());
        @(posedge clk); #1;
        start_a = 1'b0;
        check("busy_after_start", 32'(busy_a), 1);
        check("len_err_after_start", 32'(len_err_a), 0);
        while (!done && cyc < budget) begin
            bus_a.out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bus_a.in_valid  = (bi < bits.size());
            bus_a.in_bit    = (bi < bits.size()) ? bits[bi] : 1'b0;
            #1;
            cur = {bus_a.out_tail, bus_a.out_last, bus_a.out_sys, bus_a.out_par};
            if (stalled) begin
                check("stall_hold", 32'({bus_a.out_valid, cur}), 32'({1'b1, prev}));
            end
            if (bus_a.out_valid && !bus_a.out_ready) begin
                check("in_ready_when_full", 32'(bus_a.in_ready), 0);
            end
            stalled = bus_a.out_valid && !bus_a.out_ready;
            prev    = cur;
            if (bus_a.in_valid && bus_a.in_ready) bi++;
            if (bus_a.out_valid && bus_a.out_ready) begin
                got.push_back(cur);
                if (cur[2]) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus_a.in_valid = 1'b0;
        check("block_done_in_budget", 32'(done), 1);
        check("busy_after_last", 32'(busy_a), 0);
        check("state_zero_after_tail", 32'(dut_a.u_trellis.state_q), 0);
    endtask

    logic       bits[$];
    logic [3:0] got[$];
    logic [3:0] expq[$];
    logic [3:0] basic_q[$];
    logic [4:0] exp5[5];
    logic [4:0] b_bits;

    initial begin
        reset_n   = 1'b0;
        start_a   = 1'b0; blk_len_a = '0;
        start_b   = 1'b0; blk_len_b = '0;
        bus_a.in_bit = 0; bus_a.in_valid = 0; bus_a.out_ready = 0;
        bus_b.in_bit = 0; bus_b.in_valid = 0; bus_b.out_ready = 0;
        basic_q = {4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b1011, 4'b1001, 4'b1111};

        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({bus_a.out_valid, bus_a.out_sys, bus_a.out_par,
                                  bus_a.out_tail, bus_a.out_last}), 0);
        check("rst_in_ready", 32'(bus_a.in_ready), 0);
        check("rst_busy_len_err", 32'({busy_a, len_err_a}), 0);
        check("rst_state", 32'(dut_a.u_trellis.state_q), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic block, then same block under backpressure.
        bits = {1'b1, 1'b0, 1'b0, 1'b0};
        run_a(bits, 1'b0, got);
        compare_block("basic", got, basic_q);
        run_a(bits, 1'b1, got);
        compare_block("bp", got, basic_q);

        // Illegal lengths.
        start_a = 1'b1; blk_len_a = '0;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("len0_err", 32'(len_err_a), 1);
        check("len0_busy", 32'(busy_a), 0);
        @(posedge clk); #1;
        check("len0_idle", 32'({busy_a, bus_a.in_ready, bus_a.out_valid}), 0);
        start_a = 1'b1; blk_len_a = LEN_W'(6145);
        @(posedge clk); #1;
        start_a = 1'b0;
        check("lenmax_err", 32'(len_err_a), 1);
        check("lenmax_busy", 32'({busy_a, bus_a.in_ready}), 0);
        run_a(bits, 1'b0, got);
        compare_block("after_err", got, basic_q);

        // Start in DATA is ignored; then reset during TAIL.
        exp5 = '{5'b10011, 5'b10001, 5'b10001, 5'b10001, 5'b11011};
        start_a = 1'b1; blk_len_a = LEN_W'(4);
        @(posedge clk); #1;
        start_a = 1'b0;
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = (i < 4);
            bus_a.in_bit   = (i == 0);
            start_a        = (i == 1);
            blk_len_a      = LEN_W'(2);
            @(posedge clk); #1;
            check($sformatf("ign_start_out%0d", i),
                  32'({bus_a.out_valid, bus_a.out_tail, bus_a.out_last,
                       bus_a.out_sys, bus_a.out_par}), 32'(exp5[i]));
        end
        start_a = 1'b0; bus_a.in_valid = 1'b0;
        check("ign_start_len_err", 32'(len_err_a), 0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({bus_a.out_valid, bus_a.out_sys, bus_a.out_par,
                                     bus_a.out_tail, bus_a.out_last}), 0);
        check("midrst_busy", 32'({busy_a, bus_a.in_ready}), 0);
        check("midrst_state", 32'(dut_a.u_trellis.state_q), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_a(bits, 1'b0, got);
        compare_block("after_rst", got, basic_q);

        // Three back-to-back full-length random blocks against the bench model.
        for (int blk = 0; blk < 3; blk++) begin
            bits = {};
            for (int i = 0; i < 6144; i++) bits.push_back(1'($urandom_range(0, 1)));
            run_a(bits, 1'b0, got);
            ref_encode(bits, expq);
            compare_block($sformatf("b2b%0d", blk), got, expq);
        end

        // MEM=2, G_FB=1+D+D^2, G_FF=1+D^2, bits 1,1,0.
        exp5   = '{5'b10011, 5'b10010, 5'b10000, 5'b11010, 5'b11111};
        b_bits = 5'b00011;
        start_b = 1'b1; blk_len_b = LEN_W'(3);
        @(posedge clk); #1;
        start_b = 1'b0;
        check("m2_busy_start", 32'(busy_b), 1);
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_b.in_valid = (i < 3);
            bus_b.in_bit   = b_bits[i];
            @(posedge clk); #1;
            check($sformatf("m2_out%0d", i),
                  32'({bus_b.out_valid, bus_b.out_tail, bus_b.out_last,
                       bus_b.out_sys, bus_b.out_par}), 32'(exp5[i]));
        end
        bus_b.in_valid = 1'b0;
        check("m2_state_zero", 32'(dut_b.u_trellis.state_q), 0);
        @(posedge clk); #1;
        check("m2_busy_end", 32'({busy_b, bus_b.out_valid}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
